alert_scheduler: RTL

Central alert controller for the elderly-care monitor. It latches alarm events from the four monitors (fall, heart rate, temperature, medicine) and serialises them onto one caregiver alert channel using fixed priority. Each alert is held until the caregiver acknowledges it or a timeout expires. It sits between the monitor blocks and the buzzer/display/notification driver.

---
 rtl/alert_pkg.sv | 18 +
 rtl/alert_edge_latch.sv | 31 +++
 rtl/alert_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alert_pkg.sv
// Shared types and constants for the caregiver alert scheduler.
package alert_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALERT    = 2'd1,
    HOLDOFF  = 2'd2,
    ESCALATE = 2'd3
  } state_t;

  localparam logic [1:0] SRC_FALL = 2'd0;
  localparam logic [1:0] SRC_BPM  = 2'd1;
  localparam logic [1:0] SRC_TEMP = 2'd2;
  localparam logic [1:0] SRC_MED  = 2'd3;

  localparam int NUM_SRC = 4;

endpackage

// File: rtl/alert_edge_latch.sv
// Rising-edge detector feeding a sticky pending bit; a new edge beats a same-cycle clear.
module alert_edge_latch
  import alert_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic clr,
  output logic pending
);

  logic level_q;
  logic rise;

  assign rise = level & ~level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
      pending <= 1'b0;
    end else begin
      level_q <= level;
      if (rise) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alert_scheduler.sv
// Fixed-priority caregiver alert scheduler with ack timeout and holdoff.
// Optional escalation state and escalate port enabled by defining ALERT_ESCALATION_EN.
module alert_scheduler
  import alert_pkg::*;
#(
  parameter int ACK_TIMEOUT    = 64,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fall_state,
  input  logic       bpm_state,
  input  logic       temp_state,
  input  logic       medicine_reminder,
  input  logic       caregiver_ack,
  output logic       alert_valid,
  output logic [1:0] alert_code,
  output logic [3:0] pending,
  output logic [7:0] missed_count
`ifdef ALERT_ESCALATION_EN
  ,
  output logic       escalate
`endif
);

  localparam logic [15:0] TMO_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);

  state_t               state, state_nxt;
  logic [15:0]          cnt, cnt_nxt;
  logic [1:0]           code_nxt;
  logic                 miss_inc;
  logic [NUM_SRC-1:0]   src_level;
  logic [NUM_SRC-1:0]   clr_vec;
  logic                 preempt;
`ifdef ALERT_ESCALATION_EN
  logic                 esc_nxt;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [1:0] prio_enc(input logic [NUM_SRC-1:0] p);
    if (p[SRC_FALL])     return SRC_FALL;
    else if (p[SRC_BPM]) return SRC_BPM;
    else if (p[SRC_TEMP]) return SRC_TEMP;
    else                 return SRC_MED;
  endfunction

  assign src_level = {medicine_reminder, temp_state, bpm_state, fall_state};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    alert_edge_latch u_latch (
      .clk     (clk),
      .reset   (reset),
      .level   (src_level[i]),
      .clr     (clr_vec[i]),
      .pending (pending[i])
    );
  end

  // A fresh fall request takes over any lower-priority presentation.
  assign preempt = (alert_code != SRC_FALL) && pending[SRC_FALL];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = alert_code;
    miss_inc  = 1'b0;
    clr_vec   = '0;
`ifdef ALERT_ESCALATION_EN
    esc_nxt   = escalate;
`endif
    case (state)
      IDLE: begin
        if (|pending) begin
          state_nxt = ALERT;
          code_nxt  = prio_enc(pending);
          cnt_nxt   = '0;
        end
      end
      ALERT: begin
        if (caregiver_ack) begin
          clr_vec[alert_code] = 1'b1;
          state_nxt           = HOLDOFF;
          cnt_nxt             = '0;
        end else if (preempt) begin
          code_nxt = SRC_FALL;
          cnt_nxt  = '0;
        end else if (cnt == TMO_LAST) begin
          miss_inc = 1'b1;
          cnt_nxt  = '0;
`ifdef ALERT_ESCALATION_EN
          state_nxt = ESCALATE;
          esc_nxt   = 1'b1;
`else
          state_nxt = HOLDOFF;
`endif
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
`ifdef ALERT_ESCALATION_EN
      ESCALATE: begin
        if (caregiver_ack) begin
          clr_vec[alert_code] = 1'b1;
          state_nxt           = HOLDOFF;
          esc_nxt             = 1'b0;
          cnt_nxt             = '0;
        end else if (preempt) begin
          code_nxt = SRC_FALL;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      alert_code   <= SRC_FALL;
      alert_valid  <= 1'b0;
      missed_count <= '0;
`ifdef ALERT_ESCALATION_EN
      escalate     <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      alert_code  <= code_nxt;
      alert_valid <= (state_nxt == ALERT) || (state_nxt == ESCALATE);
      if (miss_inc) begin
        missed_count <= sat_inc(missed_count);
      end
`ifdef ALERT_ESCALATION_EN
      escalate    <= esc_nxt;
`endif
    end
  end

endmodule
